// File: rtl/uart_pin_host.sv
// rtl/uart_pin_host.sv - host-side command sequencer for a UART pin interface (optional macro UART_PIN_HOST_ERR_EN)
module uart_pin_host #(
    parameter int WR_PRIORITY = 0
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       wr_valid,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       rd_ready,
    input  logic       clear_req,
    output logic       clear_done,
    input  logic [1:0] rate_sel,
    output logic [3:0] ctrl,
    output logic [7:0] tx_data,
    input  logic [7:0] rx_data,
    input  logic       tx_buffer_full,
    input  logic       rx_buffer_empty,
    input  logic       uart_err,
    output logic       err_irq,
    output logic       err_seen
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_GAP} state_t;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b01;
    localparam logic [1:0] CMD_RD   = 2'b10;
    localparam logic [1:0] CMD_CLR  = 2'b11;

    state_t     state, state_nx;
    logic [1:0] cmd, cmd_nx;
    logic [1:0] rate;
    logic       clear_pend;
    logic       rr_read;      // 1: read has the next turn when both contend
    logic       wr_elig, rd_elig;
    logic       take_wr, take_rd, take_clr, rr_flip;

    assign wr_elig = wr_valid && !tx_buffer_full;
    assign rd_elig = !rx_buffer_empty && (!rd_valid || rd_ready);

    // Command selection and next-state logic; only IDLE arbitrates
    always_comb begin
        state_nx = state;
        cmd_nx   = cmd;
        take_wr  = 1'b0;
        take_rd  = 1'b0;
        take_clr = 1'b0;
        rr_flip  = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_pend) begin
                    take_clr = 1'b1;
                end else if (wr_elig && rd_elig) begin
                    if (WR_PRIORITY != 0) begin
                        take_wr = 1'b1;
                    end else begin
                        rr_flip = 1'b1;
                        take_rd = rr_read;
                        take_wr = !rr_read;
                    end
                end else if (wr_elig) begin
                    take_wr = 1'b1;
                end else if (rd_elig) begin
                    take_rd = 1'b1;
                end
                if (take_clr || take_wr || take_rd) begin
                    state_nx = S_ISSUE;
                    cmd_nx   = take_clr ? CMD_CLR : (take_wr ? CMD_WR : CMD_RD);
                end
            end
            S_ISSUE: state_nx = S_HOLD;
            S_HOLD:  state_nx = S_GAP;
            S_GAP: begin
                state_nx = S_IDLE;
                cmd_nx   = CMD_NONE;
            end
            default: begin
                state_nx = S_IDLE;
                cmd_nx   = CMD_NONE;
            end
        endcase
    end

    assign wr_ready   = take_wr;
    assign ctrl       = {((state == S_ISSUE) || (state == S_HOLD)) ? cmd : CMD_NONE, rate};
    assign clear_done = (state == S_GAP) && (cmd == CMD_CLR);

    // FSM, command, rate, clear-pending and round-robin registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state      <= S_IDLE;
            cmd        <= CMD_NONE;
            rate       <= 2'b00;
            clear_pend <= 1'b0;
            rr_read    <= 1'b0;
        end else begin
            state      <= state_nx;
            cmd        <= cmd_nx;
            clear_pend <= (clear_pend && !take_clr) || clear_req;
            if (rr_flip) begin
                rr_read <= !rr_read;
            end
            if ((state == S_IDLE) && !clear_pend && !take_wr && !take_rd) begin
                rate <= rate_sel;
            end
        end
    end

    // Write byte: captured on the handshake, held through GAP, then zeroed
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            tx_data <= 8'h00;
        end else if (take_wr) begin
            tx_data <= wr_data;
        end else if (state == S_GAP) begin
            tx_data <= 8'h00;
        end
    end

    // One-byte read output register, filled at the end of a read HOLD
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
        end else if ((state == S_HOLD) && (cmd == CMD_RD)) begin
            rd_valid <= 1'b1;
            rd_data  <= rx_data;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

`ifdef UART_PIN_HOST_ERR_EN
    logic err_d1, err_d2, err_seen_q;

    // Register uart_err and flag its rising edges
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            err_d1     <= 1'b0;
            err_d2     <= 1'b0;
            err_seen_q <= 1'b0;
        end else begin
            err_d1 <= uart_err;
            err_d2 <= err_d1;
            if (err_irq) begin
                err_seen_q <= 1'b1;
            end
        end
    end

    assign err_irq  = err_d1 && !err_d2;
    assign err_seen = err_seen_q;
`else
    logic unused_err;
    assign unused_err = uart_err;
    assign err_irq    = 1'b0;
    assign err_seen   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_pin_host.sv
// tb/tb_uart_pin_host.sv - directed table-driven bench for uart_pin_host
module tb_uart_pin_host;

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_ready = 1'b0;
    logic       clear_req = 1'b0;
    logic [1:0] rate_sel = 2'b01;
    logic [7:0] rx_data = 8'h00;
    logic       tx_buffer_full = 1'b0;
    logic       rx_buffer_empty = 1'b1;
    logic       uart_err = 1'b0;

    logic       wr_ready, rd_valid, clear_done, err_irq, err_seen;
    logic [7:0] rd_data, tx_data;
    logic [3:0] ctrl;

    logic       wr_ready_p, rd_valid_p, clear_done_p, err_irq_p, err_seen_p;
    logic [7:0] rd_data_p, tx_data_p;
    logic [3:0] ctrl_p;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_pin_host #(.WR_PRIORITY(0)) dut (
        .clk(clk), .nReset(nReset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .clear_req(clear_req),
        .clear_done(clear_done), .rate_sel(rate_sel), .ctrl(ctrl), .tx_data(tx_data), .rx_data(rx_data),
        .tx_buffer_full(tx_buffer_full), .rx_buffer_empty(rx_buffer_empty), .uart_err(uart_err),
        .err_irq(err_irq), .err_seen(err_seen)
    );

    uart_pin_host #(.WR_PRIORITY(1)) dut_p (
        .clk(clk), .nReset(nReset), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready_p),
        .rd_valid(rd_valid_p), .rd_data(rd_data_p), .rd_ready(rd_ready), .clear_req(clear_req),
        .clear_done(clear_done_p), .rate_sel(rate_sel), .ctrl(ctrl_p), .tx_data(tx_data_p), .rx_data(rx_data),
        .tx_buffer_full(tx_buffer_full), .rx_buffer_empty(rx_buffer_empty), .uart_err(uart_err),
        .err_irq(err_irq_p), .err_seen(err_seen_p)
    );

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       tf;
        logic       re;
        logic [7:0] rx;
        logic       rr;
        logic       cr;
        logic [1:0] rs;
        logic       e_wrdy;
        logic [3:0] e_ctrl;
        logic [7:0] e_tx;
        logic       e_rdv;
        logic [7:0] e_rdd;
        logic       e_cd;
    } vec_t;

    localparam int NROWS = 33;
    vec_t tbl [NROWS];

    function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic tf, input logic re,
                                input logic [7:0] rx, input logic rr, input logic cr, input logic [1:0] rs,
                                input logic e_wrdy, input logic [3:0] e_ctrl, input logic [7:0] e_tx,
                                input logic e_rdv, input logic [7:0] e_rdd, input logic e_cd);
        vec_t v;
        v.wv = wv; v.wd = wd; v.tf = tf; v.re = re; v.rx = rx; v.rr = rr; v.cr = cr; v.rs = rs;
        v.e_wrdy = e_wrdy; v.e_ctrl = e_ctrl; v.e_tx = e_tx; v.e_rdv = e_rdv; v.e_rdd = e_rdd; v.e_cd = e_cd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int codes0 [8];
    int cyc0 [8];
    int n0, n1, n1_bad, prev0, prev1, irq_cnt, wait_cnt;

    initial begin
        //       wv wd     tf re rx     rr cr rs      wrdy ctrl     tx     rdv rdd    cd
        tbl[0]  = mk(0, 8'h00, 0, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0000, 8'h00, 0, 8'h00, 0);
        tbl[1]  = mk(1, 8'hA5, 0, 1, 8'h00, 0, 0, 2'd1,  1, 4'b0001, 8'h00, 0, 8'h00, 0);
        tbl[2]  = mk(0, 8'h00, 0, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0101, 8'hA5, 0, 8'h00, 0);
        tbl[3]  = mk(0, 8'h00, 0, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0101, 8'hA5, 0, 8'h00, 0);
        tbl[4]  = mk(0, 8'h00, 0, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0001, 8'hA5, 0, 8'h00, 0);
        tbl[5]  = mk(1, 8'h11, 1, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 0, 8'h00, 0);
        tbl[6]  = mk(1, 8'h11, 1, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 0, 8'h00, 0);
        tbl[7]  = mk(1, 8'h11, 0, 1, 8'h00, 0, 0, 2'd1,  1, 4'b0001, 8'h00, 0, 8'h00, 0);
        tbl[8]  = mk(0, 8'h00, 0, 1, 8'h00, 0, 0, 2'd1,  0, 4'b0101, 8'h11, 0, 8'h00, 0);
        tbl[9]  = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b0101, 8'h11, 0, 8'h00, 0);
        tbl[10] = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b0001, 8'h11, 0, 8'h00, 0);
        tbl[11] = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 0, 8'h00, 0);
        tbl[12] = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b1001, 8'h00, 0, 8'h00, 0);
        tbl[13] = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b1001, 8'h00, 0, 8'h00, 0);
        tbl[14] = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 1, 8'h3C, 0);
        tbl[15] = mk(0, 8'h00, 0, 0, 8'h3C, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 1, 8'h3C, 0);
        tbl[16] = mk(0, 8'h00, 0, 0, 8'h77, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 1, 8'h3C, 0);
        tbl[17] = mk(0, 8'h00, 0, 0, 8'h77, 1, 0, 2'd1,  0, 4'b0001, 8'h00, 1, 8'h3C, 0);
        tbl[18] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b1001, 8'h00, 0, 8'h3C, 0);
        tbl[19] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b1001, 8'h00, 0, 8'h3C, 0);
        tbl[20] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 1, 8'h77, 0);
        tbl[21] = mk(0, 8'h00, 0, 1, 8'h77, 1, 0, 2'd1,  0, 4'b0001, 8'h00, 1, 8'h77, 0);
        tbl[22] = mk(1, 8'h5A, 0, 1, 8'h77, 0, 0, 2'd1,  1, 4'b0001, 8'h00, 0, 8'h77, 0);
        tbl[23] = mk(0, 8'h00, 0, 1, 8'h77, 0, 1, 2'd1,  0, 4'b0101, 8'h5A, 0, 8'h77, 0);
        tbl[24] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b0101, 8'h5A, 0, 8'h77, 0);
        tbl[25] = mk(0, 8'h00, 0, 1, 8'h77, 0, 1, 2'd1,  0, 4'b0001, 8'h5A, 0, 8'h77, 0);
        tbl[26] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 0, 8'h77, 0);
        tbl[27] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b1101, 8'h00, 0, 8'h77, 0);
        tbl[28] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b1101, 8'h00, 0, 8'h77, 0);
        tbl[29] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 0, 8'h77, 1);
        tbl[30] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd1,  0, 4'b0001, 8'h00, 0, 8'h77, 0);
        tbl[31] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd3,  0, 4'b0001, 8'h00, 0, 8'h77, 0);
        tbl[32] = mk(0, 8'h00, 0, 1, 8'h77, 0, 0, 2'd3,  0, 4'b0011, 8'h00, 0, 8'h77, 0);

        // reset state
        tick();
        tick();
        check("rst_ctrl", ctrl, 4'b0000);
        check("rst_tx", tx_data, 8'h00);
        check("rst_rdv", rd_valid, 1'b0);
        check("rst_rdd", rd_data, 8'h00);
        check("rst_wrdy", wr_ready, 1'b0);
        check("rst_cd", clear_done, 1'b0);
        check("rst_irq", err_irq, 1'b0);
        check("rst_seen", err_seen, 1'b0);
        nReset = 1'b1;

        // per-cycle vector table
        for (int i = 0; i < NROWS; i++) begin
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; tx_buffer_full = tbl[i].tf;
            rx_buffer_empty = tbl[i].re; rx_data = tbl[i].rx; rd_ready = tbl[i].rr;
            clear_req = tbl[i].cr; rate_sel = tbl[i].rs;
            #1;
            check($sformatf("row%0d_wrdy", i), wr_ready, tbl[i].e_wrdy);
            check($sformatf("row%0d_ctrl", i), ctrl, tbl[i].e_ctrl);
            check($sformatf("row%0d_tx", i), tx_data, tbl[i].e_tx);
            check($sformatf("row%0d_rdv", i), rd_valid, tbl[i].e_rdv);
            check($sformatf("row%0d_rdd", i), rd_data, tbl[i].e_rdd);
            check($sformatf("row%0d_cd", i), clear_done, tbl[i].e_cd);
            tick();
        end

        // continuous write+read contention: round-robin vs write priority
        wr_valid = 1'b1; wr_data = 8'hC3; tx_buffer_full = 1'b0;
        rx_buffer_empty = 1'b0; rx_data = 8'h44; rd_ready = 1'b1; clear_req = 1'b0;
        n0 = 0; n1 = 0; n1_bad = 0; prev0 = 0; prev1 = 0;
        for (int c = 0; c < 60 && n0 < 6; c++) begin
            #1;
            if (ctrl[3:2] != 2'b00 && prev0 == 0) begin
                codes0[n0] = int'(ctrl[3:2]);
                cyc0[n0] = c;
                n0++;
            end
            if (ctrl_p[3:2] != 2'b00 && prev1 == 0) begin
                n1++;
                if (ctrl_p[3:2] != 2'b01) n1_bad++;
            end
            prev0 = int'(ctrl[3:2]);
            prev1 = int'(ctrl_p[3:2]);
            tick();
        end
        check("rr_count", n0, 6);
        for (int k = 0; k < 6; k++) begin
            if (k < n0) begin
                check($sformatf("rr_code%0d", k), codes0[k], (k % 2 == 0) ? 1 : 2);
                if (k > 0) check($sformatf("rr_gap%0d", k), cyc0[k] - cyc0[k-1], 4);
            end
        end
        check("wp_count_ok", (n1 >= 5) ? 1 : 0, 1);
        check("wp_only_write", n1_bad, 0);

        // drain to idle
        wr_valid = 1'b0; rx_buffer_empty = 1'b1; rd_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        rd_ready = 1'b0;
        check("drain_ctrl", ctrl[3:2], 2'b00);

        // uart_err rising edge held high
        uart_err = 1'b1;
        irq_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (err_irq) irq_cnt++;
            tick();
        end
`ifdef UART_PIN_HOST_ERR_EN
        check("err_irq_pulses", irq_cnt, 1);
        check("err_seen_set", err_seen, 1'b1);
`else
        check("err_irq_pulses", irq_cnt, 0);
        check("err_seen_set", err_seen, 1'b0);
`endif
        uart_err = 1'b0;
        tick();
        tick();
`ifdef UART_PIN_HOST_ERR_EN
        check("err_seen_sticky", err_seen, 1'b1);
`else
        check("err_seen_sticky", err_seen, 1'b0);
`endif

        // reset in the middle of a write: abandoned, not retried
        wr_valid = 1'b1; wr_data = 8'h99;
        wait_cnt = 0;
        #1;
        while (!wr_ready && wait_cnt < 20) begin
            tick();
            wait_cnt++;
        end
        check("mid_wrdy_seen", wr_ready, 1'b1);
        tick();
        wr_valid = 1'b0;
        check("mid_issue_ctrl", ctrl[3:2], 2'b01);
        check("mid_issue_tx", tx_data, 8'h99);
        nReset = 1'b0;
        #1;
        check("mid_rst_ctrl", ctrl, 4'b0000);
        check("mid_rst_tx", tx_data, 8'h00);
        check("mid_rst_seen", err_seen, 1'b0);
        tick();
        nReset = 1'b1;
        prev0 = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (ctrl[3:2] != 2'b00) prev0++;
            tick();
        end
        check("no_retry", prev0, 0);
        check("no_retry_tx", tx_data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
